// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared mode constants and direction-counter helpers
package branch_predictor_pkg;
  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE = 1;
  function automatic int unsigned cnt_init(int unsigned bits);
    return (32'd1 << (bits - 1)) - 32'd1;
  endfunction
  function automatic int unsigned sat_step(int unsigned v, logic up, int unsigned bits);
    int unsigned mx;
    mx = (32'd1 << bits) - 32'd1;
    return up ? (v == mx ? v : v + 32'd1) : (v == 32'd0 ? v : v - 32'd1);
  endfunction
endpackage

// File: rtl/bp_btb.sv
// bp_btb: direct-mapped BTB; ports clk/reset_n, comb read (rd_pc -> hit, target), sync write (wr_en, wr_pc, wr_target), async valid clear
module bp_btb
  import branch_predictor_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int INDEX_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] rd_pc,
  output logic                 hit,
  output logic [WORD_SIZE-1:0] target,
  input  logic                 wr_en,
  input  logic [WORD_SIZE-1:0] wr_pc,
  input  logic [WORD_SIZE-1:0] wr_target
);
  localparam int N = 1 << INDEX_BITS;
  localparam int TW = WORD_SIZE - INDEX_BITS;
  logic [N-1:0] valid;
  logic [TW-1:0] tags [N];
  logic [WORD_SIZE-1:0] tgts [N];
  logic [INDEX_BITS-1:0] ridx, widx;
  assign ridx = rd_pc[INDEX_BITS-1:0];
  assign widx = wr_pc[INDEX_BITS-1:0];
  assign hit = valid[ridx] && tags[ridx] == rd_pc[WORD_SIZE-1:INDEX_BITS];
  assign target = tgts[ridx];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) valid <= '0;
    else if (wr_en) valid[widx] <= 1'b1;
  always_ff @(posedge clk)
    if (wr_en) begin
      tags[widx] <= wr_pc[WORD_SIZE-1:INDEX_BITS];
      tgts[widx] <= wr_target;
    end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BTB + saturating direction counters (bimodal/gshare); if_pc -> pred_*, upd_* trains, mispredict/mispredict_cnt report
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int INDEX_BITS = 4,
  parameter int CNT_BITS = 2,
  parameter int HIST_BITS = 4,
  parameter int MODE = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] if_pc,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [WORD_SIZE-1:0] pred_target,
  output logic [HIST_BITS-1:0] pred_hist,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic                 upd_is_cond,
  input  logic                 upd_taken,
  input  logic [WORD_SIZE-1:0] upd_target,
  input  logic [HIST_BITS-1:0] upd_hist,
  input  logic                 upd_pred_taken,
  input  logic [WORD_SIZE-1:0] upd_pred_target,
  output logic                 mispredict,
  output logic [WORD_SIZE-1:0] mispredict_cnt
);
  localparam int N = 1 << INDEX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(cnt_init(CNT_BITS));
  logic [CNT_BITS-1:0] cnt [N];
  logic [HIST_BITS-1:0] ghr;
  logic [INDEX_BITS-1:0] cidx, upd_cidx;
  logic btb_hit;
  logic [WORD_SIZE-1:0] btb_target;
  bp_btb #(.WORD_SIZE(WORD_SIZE), .INDEX_BITS(INDEX_BITS)) u_btb (
    .clk(clk),
    .reset_n(reset_n),
    .rd_pc(if_pc),
    .hit(btb_hit),
    .target(btb_target),
    .wr_en(upd_valid && upd_taken),
    .wr_pc(upd_pc),
    .wr_target(upd_target)
  );
  assign cidx = MODE == MODE_GSHARE ? if_pc[INDEX_BITS-1:0] ^ INDEX_BITS'(ghr) : if_pc[INDEX_BITS-1:0];
  assign upd_cidx = MODE == MODE_GSHARE ? upd_pc[INDEX_BITS-1:0] ^ INDEX_BITS'(upd_hist) : upd_pc[INDEX_BITS-1:0];
  assign pred_hit = btb_hit;
  assign pred_taken = btb_hit && cnt[cidx][CNT_BITS-1];
  assign pred_target = pred_taken ? btb_target : if_pc + WORD_SIZE'(1);
  assign pred_hist = ghr;
  assign mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < N; i++) cnt[i] <= CNT_INIT;
      ghr <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (upd_valid) cnt[upd_cidx] <= upd_is_cond ? CNT_BITS'(sat_step(32'(cnt[upd_cidx]), upd_taken, CNT_BITS)) : '1;
      if (upd_valid && upd_is_cond) ghr <= HIST_BITS'({ghr, upd_taken});
      if (mispredict && ~&mispredict_cnt) mispredict_cnt <= mispredict_cnt + WORD_SIZE'(1);
    end
endmodule
